// File: rtl/bf_command_runner.sv
// Brainfuck interpreter core: one opcode per enabled clock, bracket matching by linear scan.
// Optional BF_IO_EN adds the out (110) / in (111) ports; without it both opcodes are no-ops.
module bf_command_runner #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_trigger,
   input  logic              run_trigger,
   input  logic [2:0]        current_command,
   input  logic [DATA_W-1:0] current_value,
   output logic [ADDR_W-1:0] command_addr,
   output logic [ADDR_W-1:0] cell_addr,
   output logic [DATA_W-1:0] new_value,
`ifdef BF_IO_EN
   output logic [DATA_W-1:0] out_data,
   output logic              out_strobe,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
`endif
   output logic              write_trigger
);

   typedef enum logic [1:0] {EXEC, SEARCH_NEXT, SEARCH_BACK} state_t;

   localparam logic [2:0] OP_INC   = 3'b000;
   localparam logic [2:0] OP_DEC   = 3'b001;
   localparam logic [2:0] OP_OPEN  = 3'b010;
   localparam logic [2:0] OP_CLOSE = 3'b011;
   localparam logic [2:0] OP_RIGHT = 3'b100;
   localparam logic [2:0] OP_LEFT  = 3'b101;
   localparam logic [2:0] OP_OUT   = 3'b110;
   localparam logic [2:0] OP_IN    = 3'b111;

   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
   localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] depth, depth_nx, depth_scan;
   logic [ADDR_W-1:0] cmd_nx, cell_nx;
   logic [DATA_W-1:0] nv_nx;
   logic              wt_nx;
`ifdef BF_IO_EN
   logic [DATA_W-1:0] out_data_nx;
   logic              out_strobe_nx;
`endif

   // Depth after this cycle's opcode while scanning; direction decides which bracket nests.
   always_comb begin
      depth_scan = depth;
      if (state == SEARCH_NEXT) begin
         if (current_command == OP_OPEN)       depth_scan = depth + A_ONE;
         else if (current_command == OP_CLOSE) depth_scan = depth - A_ONE;
      end else if (state == SEARCH_BACK) begin
         if (current_command == OP_CLOSE)      depth_scan = depth + A_ONE;
         else if (current_command == OP_OPEN)  depth_scan = depth - A_ONE;
      end
   end

   always_comb begin
      state_nx = state;
      depth_nx = depth;
      cmd_nx   = command_addr;
      cell_nx  = cell_addr;
      nv_nx    = new_value;
      wt_nx    = 1'b0;
`ifdef BF_IO_EN
      out_data_nx   = out_data;
      out_strobe_nx = 1'b0;
`endif
      if (run_trigger) begin
         case (state)
            EXEC: begin
               cmd_nx = command_addr + A_ONE;
               case (current_command)
                  OP_INC: begin
                     nv_nx = current_value + D_ONE;
                     wt_nx = 1'b1;
                  end
                  OP_DEC: begin
                     nv_nx = current_value - D_ONE;
                     wt_nx = 1'b1;
                  end
                  OP_OPEN: begin
                     if (current_value == '0) begin
                        depth_nx = A_ONE;
                        state_nx = SEARCH_NEXT;
                     end
                  end
                  OP_CLOSE: begin
                     if (current_value != '0) begin
                        depth_nx = A_ONE;
                        cmd_nx   = command_addr - A_ONE;
                        state_nx = SEARCH_BACK;
                     end
                  end
                  OP_RIGHT: cell_nx = cell_addr + A_ONE;
                  OP_LEFT:  cell_nx = cell_addr - A_ONE;
`ifdef BF_IO_EN
                  OP_OUT: begin
                     out_data_nx   = current_value;
                     out_strobe_nx = 1'b1;
                  end
                  OP_IN: begin
                     // Stall on the same opcode until input is offered.
                     if (in_valid) begin
                        nv_nx = in_data;
                        wt_nx = 1'b1;
                     end else begin
                        cmd_nx = command_addr;
                     end
                  end
`else
                  OP_OUT, OP_IN: ;
`endif
                  default: ;
               endcase
            end
            SEARCH_NEXT: begin
               depth_nx = depth_scan;
               cmd_nx   = command_addr + A_ONE;
               if (depth_scan == '0) state_nx = EXEC;
            end
            SEARCH_BACK: begin
               depth_nx = depth_scan;
               // On the match, resume at the opcode just after the '['.
               if (depth_scan == '0) begin
                  cmd_nx   = command_addr + A_ONE;
                  state_nx = EXEC;
               end else begin
                  cmd_nx = command_addr - A_ONE;
               end
            end
            default: state_nx = EXEC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_trigger) begin
      if (reset_trigger) begin
         state         <= EXEC;
         depth         <= '0;
         command_addr  <= '0;
         cell_addr     <= '0;
         new_value     <= '0;
         write_trigger <= 1'b0;
`ifdef BF_IO_EN
         out_data      <= '0;
         out_strobe    <= 1'b0;
`endif
      end else begin
         state         <= state_nx;
         depth         <= depth_nx;
         command_addr  <= cmd_nx;
         cell_addr     <= cell_nx;
         new_value     <= nv_nx;
         write_trigger <= wt_nx;
`ifdef BF_IO_EN
         out_data      <= out_data_nx;
         out_strobe    <= out_strobe_nx;
`endif
      end
   end

endmodule

// File: tb/tb_bf_command_runner.sv
// Scoreboarded bench for bf_command_runner (default build): directed programs, hand-computed results.
module tb_bf_command_runner;

   typedef logic [40:0] tup_t; // {command_addr, cell_addr, new_value, write_trigger}

   logic        clk = 1'b0;
   logic        reset_trigger;
   logic        run_trigger;
   logic [2:0]  current_command;
   logic [7:0]  current_value;
   logic [15:0] command_addr;
   logic [15:0] cell_addr;
   logic [7:0]  new_value;
   logic        write_trigger;

   logic [2:0]  prog [32];
   tup_t        exp_q[$];
   string       name_q[$];
   int          passed = 0;
   int          total  = 0;

   bf_command_runner #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk             (clk),
      .reset_trigger   (reset_trigger),
      .run_trigger     (run_trigger),
      .current_command (current_command),
      .current_value   (current_value),
      .command_addr    (command_addr),
      .cell_addr       (cell_addr),
      .new_value       (new_value),
      .write_trigger   (write_trigger)
   );

   always #5 clk = ~clk;

   // External program memory, read combinationally.
   assign current_command = prog[command_addr[4:0]];

   function automatic tup_t outs();
      return {command_addr, cell_addr, new_value, write_trigger};
   endfunction

   task automatic check(input string name, input tup_t got, input tup_t expv);
      total++;
      if (got === expv) passed++;
      else $display("FAIL %s: got cmd=%0d cell=%0d nv=%0d wt=%0b, expected cmd=%0d cell=%0d nv=%0d wt=%0b",
                    name, got[40:25], got[24:9], got[8:1], got[0],
                    expv[40:25], expv[24:9], expv[8:1], expv[0]);
   endtask

   // Drive one cycle's inputs at the falling edge and queue the post-edge expectation.
   task automatic step(input logic run, input logic [7:0] v, input logic [15:0] ec,
                       input logic [15:0] ecell, input logic [7:0] env, input logic ewt,
                       input string name);
      run_trigger   = run;
      current_value = v;
      exp_q.push_back({ec, ecell, env, ewt});
      name_q.push_back(name);
      @(negedge clk);
   endtask

   task automatic load(input logic [2:0] p [8]);
      for (int i = 0; i < 8; i++) prog[i] = p[i];
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) check(name_q.pop_front(), outs(), exp_q.pop_front());
   end

   initial begin
      for (int i = 0; i < 32; i++) prog[i] = 3'b000;
      reset_trigger = 1'b1;
      run_trigger   = 1'b0;
      current_value = 8'd0;
      #12;
      check("reset_state", outs(), '0);

      // Arithmetic, pointer moves and wrap, I/O no-ops, run hold.
      load('{3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111});
      prog[8] = 3'b000;
      @(negedge clk);
      reset_trigger = 1'b0;
      step(1, 8'd10, 1, 0,     11,  1, "inc10");
      step(1, 8'd20, 2, 0,     19,  1, "dec20");
      step(1, 8'd0,  3, 0,     255, 1, "dec0_wrap");
      step(1, 8'd0,  4, 1,     255, 0, "right");
      step(1, 8'd0,  5, 0,     255, 0, "left");
      step(1, 8'd0,  6, 65535, 255, 0, "left_wrap");
      step(1, 8'd0,  7, 65535, 255, 0, "out_noop");
      step(1, 8'd0,  8, 65535, 255, 0, "in_noop");
      step(0, 8'd3,  8, 65535, 255, 0, "run_hold");
      step(1, 8'd3,  9, 65535, 4,   1, "inc_after_hold");

      // "[+[-]+]>" with cell 0: skip forward over the nested loop.
      reset_trigger = 1'b1;
      load('{3'b010, 3'b000, 3'b010, 3'b001, 3'b011, 3'b000, 3'b011, 3'b100});
      @(negedge clk);
      reset_trigger = 1'b0;
      step(1, 8'd0, 1, 0, 0, 0, "sn_open");
      step(1, 8'd0, 2, 0, 0, 0, "sn_skip_inc");
      step(1, 8'd0, 3, 0, 0, 0, "sn_nest");
      step(0, 8'd0, 3, 0, 0, 0, "sn_hold");
      step(1, 8'd0, 4, 0, 0, 0, "sn_skip_dec");
      step(1, 8'd0, 5, 0, 0, 0, "sn_close_inner");
      step(1, 8'd0, 6, 0, 0, 0, "sn_skip_inc2");
      step(1, 8'd0, 7, 0, 0, 0, "sn_match");
      step(1, 8'd0, 8, 1, 0, 0, "exec_after_sn");

      // ']' at 5 jumps back to the '[' at 2 with a nonzero cell.
      reset_trigger = 1'b1;
      load('{3'b100, 3'b000, 3'b010, 3'b001, 3'b100, 3'b011, 3'b000, 3'b000});
      @(negedge clk);
      reset_trigger = 1'b0;
      step(1, 8'd5, 1, 1, 0, 0, "c_right");
      step(1, 8'd5, 2, 1, 6, 1, "c_inc");
      step(1, 8'd5, 3, 1, 6, 0, "open_nonzero");
      step(1, 8'd5, 4, 1, 4, 1, "c_dec");
      step(1, 8'd5, 5, 2, 4, 0, "c_right2");
      step(1, 8'd5, 4, 2, 4, 0, "sb_enter");
      step(1, 8'd5, 3, 2, 4, 0, "sb_step");
      step(1, 8'd5, 2, 2, 4, 0, "sb_step2");
      step(1, 8'd5, 3, 2, 4, 0, "sb_match");
      step(1, 8'd5, 4, 2, 4, 1, "exec_after_sb");
      step(1, 8'd5, 5, 3, 4, 0, "c_right3");
      step(1, 8'd0, 6, 3, 4, 0, "close_zero");

      // Asynchronous reset in the middle of a forward search.
      reset_trigger = 1'b1;
      load('{3'b000, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
      @(negedge clk);
      reset_trigger = 1'b0;
      step(1, 8'd4, 1, 0, 5, 1, "d_inc");
      step(1, 8'd0, 2, 1, 5, 0, "d_right");
      step(1, 8'd0, 3, 1, 5, 0, "d_sn_enter");
      #2 reset_trigger = 1'b1;
      #1 check("async_rst_mid_search", outs(), '0);
      @(negedge clk);
      check("rst_dominates_run", outs(), '0);
      prog[0] = 3'b000;
      reset_trigger = 1'b0;
      step(1, 8'd7, 1, 0, 8, 1, "exec_after_rst");

      repeat (2) @(negedge clk);
      check("queue_drained", tup_t'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
